board_move_engine: RTL

BOARD_MOVE_ENGINE -- requirements
Module: board_move_engine

---
 rtl/board_move_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/board_move_engine.sv
// Sliding-puzzle move engine: loads a board, locates the blank, applies
// blank moves, runs the countdown and hands every new board to the drawer.
module board_move_engine (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [63:0] init_board,
  input  logic [3:0]  minute_given,
  input  logic [5:0]  second_given,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        tick_1hz,
  input  logic        draw_done,
  output logic [63:0] numbers,
  output logic        draw_req,
  output logic [9:0]  move_count,
  output logic [3:0]  minutes_left,
  output logic [5:0]  seconds_left,
  output logic        won,
  output logic        lost,
  output logic        load_err
);

  localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PLAY,
    S_DRAW,
    S_WIN,
    S_LOSE
  } state_e;

  state_e      state_q;
  logic [63:0] numbers_q;
  logic        draw_req_q;
  logic [9:0]  move_count_q;
  logic [3:0]  min_q;
  logic [5:0]  sec_q;
  logic        won_q;
  logic        lost_q;
  logic        load_err_q;
  logic [3:0]  blank_q;
  logic [3:0]  scan_idx_q;
  logic        found_q;

  logic [3:0]  min_d;
  logic [5:0]  sec_d;
  logic [63:0] board_d;
  logic [9:0]  count_d;
  logic [3:0]  target;
  logic        move_ok;
  logic [2:0]  n_moves;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [5:0]  scan_bit;
  logic [3:0]  scan_nib;
  logic [5:0]  bpos;
  logic [5:0]  tpos;
  logic        timer_en;
  logic        time_zero;
  logic        solved;

  assign scan_bit = {scan_idx_q, 2'b00};
  assign scan_nib = numbers_q[scan_bit +: 4];

  assign row = blank_q[3:2];
  assign col = blank_q[1:0];

  assign n_moves = {2'b00, move_up} + {2'b00, move_down}
                 + {2'b00, move_left} + {2'b00, move_right};

  // Only a lone move pulse is considered; edges of the grid never wrap.
  always_comb begin
    move_ok = 1'b0;
    target  = blank_q;
    if (n_moves == 3'd1) begin
      unique case (1'b1)
        move_up: begin
          move_ok = (row != 2'd0);
          target  = blank_q - 4'd4;
        end
        move_down: begin
          move_ok = (row != 2'd3);
          target  = blank_q + 4'd4;
        end
        move_left: begin
          move_ok = (col != 2'd0);
          target  = blank_q - 4'd1;
        end
        move_right: begin
          move_ok = (col != 2'd3);
          target  = blank_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bpos = {blank_q, 2'b00};
  assign tpos = {target, 2'b00};

  always_comb begin
    board_d = numbers_q;
    board_d[bpos +: 4] = numbers_q[tpos +: 4];
    board_d[tpos +: 4] = 4'h0;
  end

  assign count_d = (move_count_q == 10'h3FF) ? move_count_q
                                            : move_count_q + 10'd1;

  assign timer_en = tick_1hz &&
                    ((state_q == S_PLAY) || (state_q == S_DRAW));

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (timer_en) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 4'd0) begin
        min_d = min_q - 4'd1;
        sec_d = 6'd59;
      end
    end
  end

  assign time_zero = (min_q == 4'd0) && (sec_q == 6'd0);
  assign solved    = (numbers_q == SOLVED);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      numbers_q    <= '0;
      draw_req_q   <= 1'b0;
      move_count_q <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      load_err_q   <= 1'b0;
      blank_q      <= 4'd15;
      scan_idx_q   <= '0;
      found_q      <= 1'b0;
    end else if (load) begin
      state_q      <= S_SCAN;
      numbers_q    <= init_board;
      draw_req_q   <= 1'b0;
      move_count_q <= '0;
      min_q        <= minute_given;
      sec_q        <= second_given;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      load_err_q   <= 1'b0;
      blank_q      <= 4'd15;
      scan_idx_q   <= '0;
      found_q      <= 1'b0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
      case (state_q)
        S_IDLE: ;
        S_SCAN: begin
          scan_idx_q <= scan_idx_q + 4'd1;
          if ((scan_nib == 4'h0) && !found_q) begin
            blank_q <= scan_idx_q;
            found_q <= 1'b1;
          end
          if (scan_idx_q == 4'd15) begin
            if (found_q || (scan_nib == 4'h0)) begin
              state_q    <= S_DRAW;
              draw_req_q <= 1'b1;
            end else begin
              state_q    <= S_IDLE;
              load_err_q <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          // A legal move wins over the time-out; DRAW exit re-checks time.
          if (move_ok) begin
            numbers_q    <= board_d;
            blank_q      <= target;
            move_count_q <= count_d;
            draw_req_q   <= 1'b1;
            state_q      <= S_DRAW;
          end else if (time_zero) begin
            lost_q  <= 1'b1;
            state_q <= S_LOSE;
          end
        end
        S_DRAW: begin
          if (draw_done) begin
            draw_req_q <= 1'b0;
            if (solved) begin
              won_q   <= 1'b1;
              state_q <= S_WIN;
            end else if (time_zero) begin
              lost_q  <= 1'b1;
              state_q <= S_LOSE;
            end else begin
              state_q <= S_PLAY;
            end
          end
        end
        S_WIN: ;
        S_LOSE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign numbers      = numbers_q;
  assign draw_req     = draw_req_q;
  assign move_count   = move_count_q;
  assign minutes_left = min_q;
  assign seconds_left = sec_q;
  assign won          = won_q;
  assign lost         = lost_q;
  assign load_err     = load_err_q;

endmodule
